lfsr_decrypt_ctrl: RTL and testbench

- Hardware sequencer that performs message decryption without the program ROM.
- Reads the 64 parity-tagged encrypted bytes from data memory [ENC_BASE..ENC_BASE+63].
- Recovers the LFSR seed and the tap pattern by exploiting the guaranteed leading ASCII-space preamble.
- Writes 64 decrypted bytes to [DEC_BASE..DEC_BASE+63], then raises ack. Sits beside the core as an alternate data-memory master, using the same req/ack handshake as top_level.

---
 rtl/lfsr_decrypt_ctrl_if.sv | 29 ++
 rtl/lfsr_decrypt_ctrl.sv | 172 +++++++++++++++++
 tb/tb_lfsr_decrypt_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_decrypt_ctrl_if.sv
// Host handshake and data-memory bus of the LFSR decryption sequencer.
// Reads use mem_addr and writes use mem_waddr, because decryption reads and writes in the same cycle.
interface lfsr_decrypt_ctrl_if;
    logic       req;
    logic       ack;
    logic       busy;
    logic       err;
    logic [7:0] mem_addr;
    logic [7:0] mem_waddr;
    logic       mem_re;
    logic [7:0] mem_rdata;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [3:0] tap_sel;
    logic [6:0] lfsr_seed;
    logic [6:0] par_errs;

    modport master (
        input  req, mem_rdata,
        output ack, busy, err, mem_addr, mem_waddr, mem_re, mem_we, mem_wdata,
        output tap_sel, lfsr_seed, par_errs
    );

    modport slave (
        output req, mem_rdata,
        input  ack, busy, err, mem_addr, mem_waddr, mem_re, mem_we, mem_wdata,
        input  tap_sel, lfsr_seed, par_errs
    );
endinterface

// File: rtl/lfsr_decrypt_ctrl.sv
// Decrypts a parity-tagged LFSR-encrypted message, recovering seed and tap from the space preamble.
// Fetch preamble -> search tap table -> pipelined read/decrypt/write -> DONE.
module lfsr_decrypt_ctrl #(
    parameter logic [7:0] ENC_BASE = 8'd64,
    parameter logic [7:0] DEC_BASE = 8'd0,
    parameter int         MSG_LEN  = 64,
    parameter int         PRE_CHK  = 10
) (
    input  logic                 clk,
    input  logic                 init,
    lfsr_decrypt_ctrl_if.master  bus
);
    localparam int         IW   = $clog2(PRE_CHK);
    localparam logic [7:0] LEN8 = 8'(MSG_LEN);
    localparam logic [7:0] PRE8 = 8'(PRE_CHK);

    typedef enum logic [2:0] {IDLE, FETCH, SEARCH, DECRYPT, DONE} state_t;

    state_t     state, state_n;
    logic       req_q;
    logic [7:0] cnt, cnt_n;
    logic [7:0] j, j_n;
    logic [3:0] k, k_n;
    logic [6:0] s, s_n, s_step;
    logic [6:0] seed, seed_n;
    logic [6:0] pbuf [PRE_CHK];
    logic [6:0] pbuf_n [PRE_CHK];
    logic [3:0] tap_sel, tap_sel_n;
    logic       err, err_n;
    logic [6:0] par_errs, par_n;

    function automatic logic [6:0] tap_rom(input logic [3:0] i);
        case (i)
            4'd0:    return 7'h60;
            4'd1:    return 7'h48;
            4'd2:    return 7'h78;
            4'd3:    return 7'h72;
            4'd4:    return 7'h6A;
            4'd5:    return 7'h69;
            4'd6:    return 7'h5C;
            4'd7:    return 7'h7E;
            4'd8:    return 7'h7B;
            default: return 7'h00;
        endcase
    endfunction

    // k is frozen at the matched index, so the same stepper serves search and decrypt.
    assign s_step = {s[5:0], ^(s & tap_rom(k))};

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        j_n           = j;
        k_n           = k;
        s_n           = s;
        seed_n        = seed;
        pbuf_n        = pbuf;
        tap_sel_n     = tap_sel;
        err_n         = err;
        par_n         = par_errs;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 8'd0;
        bus.mem_waddr = 8'd0;
        bus.mem_wdata = 8'd0;
        case (state)
            IDLE: begin
                if (req_q && !bus.req) begin
                    state_n = FETCH;
                    cnt_n   = 8'd0;
                    par_n   = 7'd0;
                    err_n   = 1'b0;
                end
            end
            FETCH: begin
                if (cnt < PRE8) begin
                    bus.mem_re   = 1'b1;
                    bus.mem_addr = ENC_BASE + cnt;
                end
                if (cnt != 8'd0)
                    pbuf_n[IW'(cnt - 8'd1)] = bus.mem_rdata[6:0];
                cnt_n = cnt + 8'd1;
                if (cnt == PRE8) begin
                    seed_n  = pbuf[0] ^ 7'h20;
                    s_n     = pbuf[0] ^ 7'h20;
                    k_n     = 4'd0;
                    j_n     = 8'd1;
                    state_n = SEARCH;
                end
            end
            SEARCH: begin
                if ((s_step ^ pbuf[IW'(j)]) == 7'h20) begin
                    if (j == PRE8 - 8'd1) begin
                        tap_sel_n = k;
                        s_n       = seed;
                        cnt_n     = 8'd0;
                        state_n   = DECRYPT;
                    end else begin
                        j_n = j + 8'd1;
                        s_n = s_step;
                    end
                end else if (k == 4'd8) begin
                    err_n     = 1'b1;
                    tap_sel_n = 4'hF;
                    state_n   = DONE;
                end else begin
                    k_n = k + 4'd1;
                    j_n = 8'd1;
                    s_n = seed;
                end
            end
            DECRYPT: begin
                if (cnt < LEN8) begin
                    bus.mem_re   = 1'b1;
                    bus.mem_addr = ENC_BASE + cnt;
                end
                // Byte cnt-1 arrives this cycle; s still holds its keystream value.
                if (cnt != 8'd0) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_waddr = DEC_BASE + cnt - 8'd1;
                    bus.mem_wdata = {1'b0, bus.mem_rdata[6:0] ^ s};
                    s_n           = s_step;
                    if ((^bus.mem_rdata) && par_errs != 7'h7F)
                        par_n = par_errs + 7'd1;
                end
                cnt_n = cnt + 8'd1;
                if (cnt == LEN8)
                    state_n = DONE;
            end
            DONE: begin
                if (bus.req)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            cnt      <= 8'd0;
            j        <= 8'd0;
            k        <= 4'd0;
            s        <= 7'd0;
            seed     <= 7'd0;
            pbuf     <= '{default: 7'd0};
            tap_sel  <= 4'hF;
            err      <= 1'b0;
            par_errs <= 7'd0;
        end else begin
            state    <= state_n;
            req_q    <= bus.req;
            cnt      <= cnt_n;
            j        <= j_n;
            k        <= k_n;
            s        <= s_n;
            seed     <= seed_n;
            pbuf     <= pbuf_n;
            tap_sel  <= tap_sel_n;
            err      <= err_n;
            par_errs <= par_n;
        end
    end

    assign bus.ack       = (state == DONE);
    assign bus.busy      = (state == FETCH) || (state == SEARCH) || (state == DECRYPT);
    assign bus.err       = err;
    assign bus.tap_sel   = tap_sel;
    assign bus.lfsr_seed = seed;
    assign bus.par_errs  = par_errs;
endmodule

// File: tb/tb_lfsr_decrypt_ctrl.sv
// Directed bench for lfsr_decrypt_ctrl: encrypts a known message into a behavioural memory
// and checks recovered tap/seed, decrypted bytes, parity count, error path and reset abort.
module tb_lfsr_decrypt_ctrl;
    localparam logic [7:0] ENC = 8'd64;
    localparam logic [7:0] DEC = 8'd0;
    localparam int BUDGET = 10 + 1 + 81 + 65 + 2;

    logic clk = 1'b0;
    logic init;
    always #5 clk = ~clk;

    lfsr_decrypt_ctrl_if bus();
    lfsr_decrypt_ctrl dut (.clk(clk), .init(init), .bus(bus));

    logic [7:0] dm [256];
    logic       tb_we;
    logic [7:0] tb_addr, tb_wdata;
    int         acc_cnt = 0;
    int         pass_cnt = 0;
    int         total = 0;

    logic [6:0] taps [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
    logic [6:0] seeds [3] = '{7'h01, 7'h55, 7'h7F};
    string msg = "Knowledge comes, but wisdom lingers";

    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= dm[bus.mem_addr];
        if (bus.mem_we) dm[bus.mem_waddr] <= bus.mem_wdata;
        if (tb_we) dm[tb_addr] <= tb_wdata;
        if (bus.mem_re || bus.mem_we) acc_cnt <= acc_cnt + 1;
    end

    function automatic logic [6:0] stp(input logic [6:0] st, input logic [6:0] tp);
        return {st[5:0], ^(st & tp)};
    endfunction

    function automatic logic [7:0] plain(input int i);
        if (i < 10 || i >= 10 + msg.len()) return 8'h20;
        return msg[i - 10];
    endfunction

    // First table entry whose keystream reproduces the true one across the preamble.
    function automatic int exp_tap(input int ti, input logic [6:0] seed);
        for (int kk = 0; kk < 9; kk++) begin
            logic [6:0] a = seed, b = seed;
            bit same = 1'b1;
            for (int i = 1; i < 10; i++) begin
                a = stp(a, taps[kk]);
                b = stp(b, taps[ti]);
                if (a != b) same = 1'b0;
            end
            if (same) return kk;
        end
        return ti;
    endfunction

    function automatic int dec_bad(input int ti, input int te, input logic [6:0] seed, input int lo, input int hi);
        logic [6:0] st = seed, se = seed, pl;
        logic [7:0] p;
        int bad = 0;
        for (int i = 0; i < 64; i++) begin
            p  = plain(i);
            pl = p[6:0] ^ st ^ se;
            if (i >= lo && i <= hi && dm[DEC + 8'(i)] !== {1'b0, pl}) bad++;
            st = stp(st, taps[ti]);
            se = stp(se, taps[te]);
        end
        return bad;
    endfunction

    function automatic int dec_sentinel_bad(input int lo, input int hi);
        int bad = 0;
        for (int i = lo; i <= hi; i++)
            if (dm[DEC + 8'(i)] !== 8'hEE) bad++;
        return bad;
    endfunction

    task automatic load(input int ti, input logic [6:0] seed, input int fa, input int fb, input bit all80);
        logic [6:0] st = seed, lo;
        logic [7:0] p, b;
        for (int i = 0; i < 64; i++) begin
            p  = plain(i);
            lo = p[6:0] ^ st;
            b  = {^lo, lo};
            if (i == fa || i == fb) b[7] = ~b[7];
            if (all80) b = 8'h80;
            @(negedge clk);
            tb_we = 1'b1; tb_addr = ENC + 8'(i); tb_wdata = b;
            st = stp(st, taps[ti]);
        end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            tb_we = 1'b1; tb_addr = DEC + 8'(i); tb_wdata = 8'hEE;
        end
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic run(output int cyc, output bit ok);
        ok = 1'b0; cyc = BUDGET + 1;
        @(negedge clk);
        bus.req = 1'b0;
        for (int c = 1; c <= 300 && !ok; c++) begin
            @(negedge clk);
            if (bus.ack) begin ok = 1'b1; cyc = c; end
        end
    endtask

    task automatic release_req();
        @(negedge clk);
        bus.req = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if ({bus.ack, bus.busy, bus.err, bus.mem_re, bus.mem_we} !== 5'b0)
            $display("FAIL %s_strobes: got %b want 00000", tag, {bus.ack, bus.busy, bus.err, bus.mem_re, bus.mem_we});
        else pass_cnt++;
        total++;
        if ({bus.mem_addr, bus.mem_wdata} !== 16'h0)
            $display("FAIL %s_addr_data: got %h want 0000", tag, {bus.mem_addr, bus.mem_wdata});
        else pass_cnt++;
        total++;
        if ({bus.tap_sel, bus.lfsr_seed, bus.par_errs} !== {4'hF, 7'd0, 7'd0})
            $display("FAIL %s_results: got tap %h seed %h par %h want F 00 00", tag, bus.tap_sel, bus.lfsr_seed, bus.par_errs);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        init = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idle_hold();
        int a0 = acc_cnt;
        bit seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (bus.ack || bus.busy) seen = 1'b1;
        end
        total++;
        if (acc_cnt - a0 != 0) $display("FAIL idle_hold_access: got %0d want 0", acc_cnt - a0);
        else pass_cnt++;
        total++;
        if (seen) $display("FAIL idle_hold_ack: got 1 want 0");
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int cyc; bit ok; int bad;
        load(0, 7'h01, -1, -1, 1'b0);
        run(cyc, ok);
        total++;
        if (!ok || cyc > BUDGET) $display("FAIL basic_latency: got %0d cycles want <= %0d", cyc, BUDGET);
        else pass_cnt++;
        total++;
        if ({bus.tap_sel, bus.lfsr_seed} !== {4'd0, 7'h01})
            $display("FAIL basic_tap_seed: got %h %h want 0 01", bus.tap_sel, bus.lfsr_seed);
        else pass_cnt++;
        total++;
        if ({bus.err, bus.par_errs} !== 8'h00) $display("FAIL basic_err_par: got %b %h want 0 00", bus.err, bus.par_errs);
        else pass_cnt++;
        bad = dec_bad(0, 0, 7'h01, 0, 63);
        total++;
        if (bad != 0) $display("FAIL basic_bytes: got %0d bad bytes want 0", bad);
        else pass_cnt++;
        release_req();
        total++;
        if (bus.ack !== 1'b0) $display("FAIL release_ack: got %b want 0", bus.ack);
        else pass_cnt++;
        total++;
        if ({bus.tap_sel, bus.lfsr_seed} !== {4'd0, 7'h01})
            $display("FAIL release_held: got %h %h want 0 01", bus.tap_sel, bus.lfsr_seed);
        else pass_cnt++;
    endtask

    task automatic test_all_taps();
        int cyc; bit ok; int bad; int te;
        for (int ti = 0; ti < 9; ti++) begin
            for (int si = 0; si < 3; si++) begin
                load(ti, seeds[si], -1, -1, 1'b0);
                run(cyc, ok);
                te = exp_tap(ti, seeds[si]);
                total++;
                if (!ok || bus.tap_sel !== 4'(te))
                    $display("FAIL taps_sel t%0d s%h: got %h (ack %b) want %0d", ti, seeds[si], bus.tap_sel, ok, te);
                else pass_cnt++;
                bad = dec_bad(ti, te, seeds[si], 0, 63);
                total++;
                if (bad != 0) $display("FAIL taps_bytes t%0d s%h: got %0d bad want 0", ti, seeds[si], bad);
                else pass_cnt++;
                release_req();
            end
        end
    endtask

    task automatic test_parity();
        int cyc; bit ok; int bad;
        load(3, 7'h55, 20, 40, 1'b0);
        run(cyc, ok);
        total++;
        if (!ok || bus.par_errs !== 7'd2) $display("FAIL parity_count: got %0d (ack %b) want 2", bus.par_errs, ok);
        else pass_cnt++;
        bad = dec_bad(3, exp_tap(3, 7'h55), 7'h55, 0, 63);
        total++;
        if (bad != 0) $display("FAIL parity_bytes: got %0d bad want 0", bad);
        else pass_cnt++;
        release_req();
    endtask

    task automatic test_rerun_clears();
        bit ok = 1'b0;
        load(0, 7'h01, -1, -1, 1'b0);
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.par_errs} !== {1'b1, 7'd0})
            $display("FAIL rerun_clear: got busy %b par %0d want 1 0", bus.busy, bus.par_errs);
        else pass_cnt++;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (bus.ack) ok = 1'b1;
        end
        total++;
        if (!ok || bus.par_errs !== 7'd0) $display("FAIL rerun_par: got %0d (ack %b) want 0", bus.par_errs, ok);
        else pass_cnt++;
        release_req();
    endtask

    task automatic test_err();
        int cyc; bit ok; int bad;
        load(0, 7'h01, -1, -1, 1'b1);
        run(cyc, ok);
        total++;
        if ({ok, bus.ack, bus.err, bus.tap_sel} !== {1'b1, 1'b1, 1'b1, 4'hF})
            $display("FAIL err_flags: got ack %b err %b tap %h want 1 1 F", bus.ack, bus.err, bus.tap_sel);
        else pass_cnt++;
        bad = dec_sentinel_bad(0, 63);
        total++;
        if (bad != 0) $display("FAIL err_no_write: got %0d written want 0", bad);
        else pass_cnt++;
        release_req();
    endtask

    task automatic test_mid_reset();
        bit found = 1'b0; int cyc; bit ok; int bad; int te;
        load(1, 7'h55, -1, -1, 1'b0);
        @(negedge clk);
        bus.req = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (bus.mem_we && bus.mem_waddr == DEC + 8'd30) found = 1'b1;
        end
        total++;
        if (!found) $display("FAIL midrst_reach: got no write of byte 30 want one");
        else pass_cnt++;
        init = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        init = 1'b1;
        repeat (2) @(negedge clk);
        bad = dec_sentinel_bad(31, 63);
        total++;
        if (bad != 0) $display("FAIL midrst_tail: got %0d written want 0", bad);
        else pass_cnt++;
        te = exp_tap(1, 7'h55);
        bad = dec_bad(1, te, 7'h55, 0, 29);
        total++;
        if (bad != 0) $display("FAIL midrst_head: got %0d bad want 0", bad);
        else pass_cnt++;
        release_req();
        run(cyc, ok);
        total++;
        if (!ok || bus.tap_sel !== 4'(te)) $display("FAIL midrst_rerun_tap: got %h (ack %b) want %0d", bus.tap_sel, ok, te);
        else pass_cnt++;
        bad = dec_bad(1, te, 7'h55, 0, 63);
        total++;
        if (bad != 0) $display("FAIL midrst_rerun_bytes: got %0d bad want 0", bad);
        else pass_cnt++;
        release_req();
    endtask

    initial begin
        init = 1'b1;
        bus.req = 1'b1;
        tb_we = 1'b0; tb_addr = 8'd0; tb_wdata = 8'd0;
        #2 init = 1'b0;
        test_reset();
        test_idle_hold();
        test_basic();
        test_all_taps();
        test_parity();
        test_rerun_clears();
        test_err();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
